// File: rtl/counter_step_ctrl_if.sv
// Button/step bundle between the push-button front end and whoever drives or observes it.
interface counter_step_ctrl_if;
  logic BTN_UP;
  logic BTN_DWN;
  logic ENABLE;
  logic EN;
  logic UP_DWN;
  logic LOCKED;

  modport master (
    output BTN_UP, BTN_DWN, ENABLE,
    input  EN, UP_DWN, LOCKED
  );

  modport slave (
    input  BTN_UP, BTN_DWN, ENABLE,
    output EN, UP_DWN, LOCKED
  );
endinterface

// File: rtl/counter_step_ctrl.sv
// Push-button front end for the up/down counter: synchronize, debounce, and decode presses
// into single-cycle EN step pulses with auto-repeat, a direction flag and a conflict lockout.
module counter_step_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_CYCLES   = 16
) (
  input logic               CLK,
  input logic               RST,
  counter_step_ctrl_if.slave bus
);

  localparam logic [7:0]  DB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] REP_LAST = 16'(REPEAT_CYCLES - 1);
  localparam bit          REP_ON   = (REPEAT_CYCLES != 0);

  typedef enum logic [1:0] {IDLE, UP_HELD, DWN_HELD, LOCK} state_t;

  // index 0 = up button, index 1 = down button
  logic [1:0]      up_sync_q, dwn_sync_q;
  logic [1:0]      btn_sync;
  logic [1:0]      db_q, db_d;
  logic [1:0][7:0] db_cnt_q, db_cnt_d;

  state_t      state_q;
  logic [15:0] rep_q;
  logic        en_q, up_dwn_q, locked_q;
  logic        btn_u, btn_d, own_btn, other_btn, rep_hit;

  assign btn_sync = {dwn_sync_q[1], up_sync_q[1]};
  assign btn_u    = db_q[0];
  assign btn_d    = db_q[1];

  always_comb begin
    db_d     = db_q;
    db_cnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (btn_sync[i] != db_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          db_d[i] = ~db_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      up_sync_q  <= '0;
      dwn_sync_q <= '0;
      db_q       <= '0;
      db_cnt_q   <= '0;
    end else begin
      up_sync_q  <= {up_sync_q[0], bus.BTN_UP};
      dwn_sync_q <= {dwn_sync_q[0], bus.BTN_DWN};
      db_q       <= db_d;
      db_cnt_q   <= db_cnt_d;
    end
  end

  always_comb begin
    own_btn   = 1'b0;
    other_btn = 1'b0;
    rep_hit   = REP_ON && (rep_q == REP_LAST);
    if (state_q == UP_HELD) begin
      own_btn   = btn_u;
      other_btn = btn_d;
    end else if (state_q == DWN_HELD) begin
      own_btn   = btn_d;
      other_btn = btn_u;
    end
  end

  // The repeat counter keeps its phase while ENABLE is low, so a masked step is lost, not delayed.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      rep_q    <= '0;
      en_q     <= 1'b0;
      up_dwn_q <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      en_q     <= 1'b0;
      locked_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (btn_u && btn_d) begin
            state_q  <= LOCK;
            locked_q <= 1'b1;
          end else if (btn_u) begin
            state_q  <= UP_HELD;
            up_dwn_q <= 1'b1;
            en_q     <= bus.ENABLE;
            rep_q    <= '0;
          end else if (btn_d) begin
            state_q  <= DWN_HELD;
            up_dwn_q <= 1'b0;
            en_q     <= bus.ENABLE;
            rep_q    <= '0;
          end
        end
        UP_HELD, DWN_HELD: begin
          if (other_btn) begin
            state_q  <= LOCK;
            locked_q <= 1'b1;
          end else if (!own_btn) begin
            state_q <= IDLE;
          end else if (REP_ON) begin
            if (rep_hit) begin
              rep_q <= '0;
              en_q  <= bus.ENABLE;
            end else begin
              rep_q <= rep_q + 16'd1;
            end
          end
        end
        LOCK: begin
          if (!btn_u && !btn_d) begin
            state_q <= IDLE;
          end else begin
            locked_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.EN     = en_q;
  assign bus.UP_DWN = up_dwn_q;
  assign bus.LOCKED = locked_q;

endmodule

// File: tb/tb_counter_step_ctrl.sv
// Bench for counter_step_ctrl: directed button scenarios plus random presses, bounce and
// ENABLE gating, checked every cycle against a timing-level model of the press rules.
module tb_counter_step_ctrl;

  localparam int DEB = 4;
  localparam int REP = 16;

  logic CLK;
  logic RST;
  int   cyc;
  int   n_checks;
  int   n_pass;
  int   pulses[$];

  counter_step_ctrl_if ifc ();

  counter_step_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_CYCLES  (REP)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(ifc)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
  endtask

  // Reference: button level seen two edges late, flipped after DEB edges of disagreement;
  // a press steps on entry and then every REP edges of continuous holding.
  localparam int M_IDLE = 0, M_UP = 1, M_DWN = 2, M_LOCK = 3;
  bit m_s1[2], m_s2[2], m_deb[2];
  int m_run[2];
  int m_mode, m_age;
  bit m_en, m_ud, m_lock;

  initial begin
    forever begin
      @(posedge CLK or posedge RST);
      if (RST) begin
        for (int i = 0; i < 2; i++) begin
          m_s1[i] = 0; m_s2[i] = 0; m_deb[i] = 0; m_run[i] = 0;
        end
        m_mode = M_IDLE; m_age = 0; m_en = 0; m_ud = 0; m_lock = 0;
      end else begin
        bit u, d, step, own, other;
        u = m_deb[0]; d = m_deb[1]; step = 0;
        case (m_mode)
          M_IDLE: begin
            if (u && d) m_mode = M_LOCK;
            else if (u) begin m_mode = M_UP; m_ud = 1; step = 1; m_age = 0; end
            else if (d) begin m_mode = M_DWN; m_ud = 0; step = 1; m_age = 0; end
          end
          M_UP, M_DWN: begin
            own   = (m_mode == M_UP) ? u : d;
            other = (m_mode == M_UP) ? d : u;
            if (other) m_mode = M_LOCK;
            else if (!own) m_mode = M_IDLE;
            else begin
              m_age++;
              if (REP > 0 && (m_age % REP) == 0) step = 1;
            end
          end
          default: if (!u && !d) m_mode = M_IDLE;
        endcase
        m_en   = step && ifc.ENABLE;
        m_lock = (m_mode == M_LOCK);
        for (int i = 0; i < 2; i++) begin
          if (m_s2[i] != m_deb[i]) begin
            m_run[i]++;
            if (m_run[i] >= DEB) begin m_deb[i] = !m_deb[i]; m_run[i] = 0; end
          end else begin
            m_run[i] = 0;
          end
          m_s2[i] = m_s1[i];
        end
        m_s1[0] = ifc.BTN_UP;
        m_s1[1] = ifc.BTN_DWN;
      end
    end
  end

  always @(negedge CLK) begin
    chk("model_EN", ifc.EN, m_en);
    chk("model_UP_DWN", ifc.UP_DWN, m_ud);
    chk("model_LOCKED", ifc.LOCKED, m_lock);
    if (ifc.EN === 1'b1) pulses.push_back(cyc);
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic check_pulses(input string name, input int n, input int e0, input int e1, input int e2);
    int ev[3];
    ev = '{e0, e1, e2};
    chk({name, "_count"}, pulses.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < pulses.size()) chk({name, "_edge"}, pulses[i], ev[i]);
      else chk({name, "_edge"}, -1, ev[i]);
    end
  endtask

  task automatic chk_outputs_zero(input string name);
    chk({name, "_EN"}, ifc.EN, 0);
    chk({name, "_UP_DWN"}, ifc.UP_DWN, 0);
    chk({name, "_LOCKED"}, ifc.LOCKED, 0);
  endtask

  initial begin
    int  k, r;
    bit  want_u, want_d;
    n_checks = 0; n_pass = 0;
    RST = 0; ifc.BTN_UP = 0; ifc.BTN_DWN = 0; ifc.ENABLE = 1;
    #1 RST = 1;
    for (int i = 0; i < 3; i++) begin
      cycles(1);
      chk_outputs_zero("init_reset");
    end
    RST = 0;
    cycles(5);

    // Clean press held 12 edges: one step at k+6, no repeat.
    pulses.delete(); ifc.BTN_UP = 1; k = cyc + 1;
    cycles(12); ifc.BTN_UP = 0;
    cycles(20);
    check_pulses("clean_up", 1, k + 6, 0, 0);
    chk("clean_up_dir", ifc.UP_DWN, 1);

    // Bounce shorter than the debounce window.
    pulses.delete();
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK); ifc.BTN_UP = (i % 2 == 0);
    end
    @(negedge CLK); ifc.BTN_UP = 0;
    cycles(15);
    check_pulses("bounce", 0, 0, 0, 0);
    chk("bounce_dir", ifc.UP_DWN, 1);

    // Asynchronous reset mid-cycle clears outputs before the next edge.
    @(negedge CLK); #2 RST = 1;
    #1 chk_outputs_zero("async_reset");
    for (int i = 0; i < 3; i++) begin
      cycles(1);
      chk_outputs_zero("held_reset");
    end
    RST = 0;
    cycles(5);

    // Down held 44 edges: steps at k+6, k+22, k+38.
    pulses.delete(); ifc.BTN_DWN = 1; k = cyc + 1;
    cycles(44); ifc.BTN_DWN = 0;
    cycles(20);
    check_pulses("dwn_repeat", 3, k + 6, k + 22, k + 38);
    chk("dwn_repeat_dir", ifc.UP_DWN, 0);

    // Same press with ENABLE low for edges k+20..k+24: k+22 dropped, k+38 kept.
    pulses.delete(); ifc.BTN_DWN = 1; k = cyc + 1;
    cycles(20); ifc.ENABLE = 0;
    cycles(5);  ifc.ENABLE = 1;
    cycles(19); ifc.BTN_DWN = 0;
    cycles(20);
    check_pulses("dwn_gated", 2, k + 6, k + 38, 0);
    chk("dwn_gated_dir", ifc.UP_DWN, 0);

    // Both buttons at once: lockout from k+6, held until both released and debounced.
    pulses.delete(); ifc.BTN_UP = 1; ifc.BTN_DWN = 1; k = cyc + 1;
    cycles(6);  chk("lock_before", ifc.LOCKED, 0);
    cycles(1);  chk("lock_set", ifc.LOCKED, 1);
    cycles(4);  ifc.BTN_UP = 0;
    cycles(15); chk("lock_up_released", ifc.LOCKED, 1);
    ifc.BTN_DWN = 0; r = cyc + 1;
    cycles(6);  chk("lock_exit_before", ifc.LOCKED, 1);
    cycles(1);  chk("lock_exit", ifc.LOCKED, 0);
    cycles(10);
    check_pulses("lock", 0, 0, 0, 0);

    // Reset while up is held: fresh first step 6 edges after reset release.
    ifc.BTN_UP = 1;
    cycles(15);
    chk("pre_reset_dir", ifc.UP_DWN, 1);
    #2 RST = 1;
    #1 chk_outputs_zero("reset_in_held");
    cycles(2);
    RST = 0; k = cyc + 1; pulses.delete();
    cycles(12);
    check_pulses("post_reset", 1, k + 6, 0, 0);
    chk("post_reset_dir", ifc.UP_DWN, 1);
    ifc.BTN_UP = 0;
    cycles(20);

    // Random presses, short glitches, ENABLE gating and occasional resets.
    want_u = 0; want_d = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      if ($urandom_range(0, 39) == 0) want_u = !want_u;
      if ($urandom_range(0, 39) == 0) want_d = !want_d;
      ifc.BTN_UP  = want_u ^ ($urandom_range(0, 15) == 0);
      ifc.BTN_DWN = want_d ^ ($urandom_range(0, 15) == 0);
      ifc.ENABLE  = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 599) == 0) begin
        #2 RST = 1;
      end else if (RST) begin
        RST = 0;
      end
    end
    ifc.BTN_UP = 0; ifc.BTN_DWN = 0; ifc.ENABLE = 1; RST = 0;
    cycles(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
